wb_mem_monitor: RTL and testbench

WB_MEM_MONITOR -- requirements
Module: wb_mem_monitor

---
 rtl/wb_mem_monitor.sv | 139 +++++++++++++
 tb/tb_wb_mem_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_monitor.sv
// Wishbone-style word memory with wait states, plus a firmware run monitor
// that tracks the exit register, a hang timeout and the first calculate instruction.
module wb_mem_monitor #(
  parameter int unsigned     AW          = 30,
  parameter int unsigned     DEPTH       = 65536,
  parameter int unsigned     WAIT_STATES = 1,
  parameter logic [AW-1:0]   EXIT_ADR    = 30'h0400_0001,
  parameter logic [31:0]     EXIT_DAT    = 32'h0000_00ad,
  parameter int unsigned     TIMEOUT     = 2000000,
  parameter logic [31:0]     INSN_MATCH  = 32'h0000_2027,
  parameter logic [31:0]     INSN_MASK   = 32'hfe00_707f,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    adr,
  input  logic [31:0]      dat,
  input  logic [3:0]       sel,
  input  logic             we,
  input  logic             cyc,
  output logic [31:0]      rdt,
  output logic             ack,
  output logic             err,
  input  logic [31:0]      insn,
  input  logic             insn_valid,
  output logic             done,
  output logic             timeout,
  output logic             calc_seen,
  output logic [CNT_W-1:0] calc_start_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [3:0]       WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t           state_q;
  logic [3:0]       wcnt_q;
  logic             ack_q, err_q, rd_ok_q;
  logic             done_q, timeout_q, calc_seen_q;
  logic [CNT_W-1:0] calc_cnt_q, cnt_q, cnt_d;
  logic [31:0]      rd_word_q;
  logic [31:0]      mem [0:DEPTH-1];

  logic             in_range, is_exit, fire, exit_hit, calc_hit, stopped;
  logic             mem_we, err_cond, rd_ok;
  logic [IDX_W-1:0] idx;

  assign idx = adr[IDX_W-1:0];

  always_comb begin
    in_range = {1'b0, adr} < DEPTH_W;
    is_exit  = (adr == EXIT_ADR);
    // fire marks the edge that enters ACK: commit point for writes, exit and read data
    fire     = cyc && (((state_q == S_IDLE) && (WAIT_STATES == 0)) ||
                       ((state_q == S_WAIT) && (wcnt_q == 4'd0)));
    exit_hit = fire && we && is_exit && (dat == EXIT_DAT) && (sel == 4'hF);
    err_cond = !in_range && !is_exit;
    rd_ok    = in_range && !is_exit;
    mem_we   = fire && we && rd_ok && !reset;
    calc_hit = insn_valid && ((insn & INSN_MASK) == INSN_MATCH) && !calc_seen_q;
    stopped  = done_q || timeout_q;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Read-before-write RAM port; rd_word_q is only exposed while ack is high.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel[i]) mem[idx][8*i +: 8] <= dat[8*i +: 8];
      end
    end
    rd_word_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      calc_seen_q <= 1'b0;
      calc_cnt_q  <= '0;
      cnt_q       <= '0;
    end else begin
      ack_q   <= fire;
      err_q   <= fire && err_cond;
      rd_ok_q <= fire && rd_ok;

      case (state_q)
        S_IDLE: begin
          if (cyc) begin
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!cyc)                 state_q <= S_IDLE;
          else if (wcnt_q == 4'd0)  state_q <= S_ACK;
          else                      wcnt_q  <= wcnt_q - 4'd1;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (exit_hit) done_q <= 1'b1;
      // an exit landing on the timeout cycle wins over the timeout
      if (!stopped) begin
        cnt_q <= cnt_d;
        if (!exit_hit && (cnt_d == TO_CNT)) timeout_q <= 1'b1;
      end

      if (calc_hit) begin
        calc_seen_q <= 1'b1;
        calc_cnt_q  <= cnt_q;
      end
    end
  end

  assign rdt            = (ack_q && rd_ok_q) ? rd_word_q : '0;
  assign ack            = ack_q;
  assign err            = err_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign calc_seen      = calc_seen_q;
  assign calc_start_cnt = calc_cnt_q;
  assign cycle_cnt      = cnt_q;

endmodule

// File: tb/tb_wb_mem_monitor.sv
// Directed bench for wb_mem_monitor: scoreboarded bus cycles on a 1-wait-state
// instance and abort/reset cases on a 3-wait-state instance.
module tb_wb_mem_monitor;

  localparam int unsigned DEPTH    = 256;
  localparam logic [29:0] EXIT_ADR = 30'h0400_0001;
  localparam logic [31:0] EXIT_DAT = 32'h0000_00ad;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc1 = 1'b0, cyc3 = 1'b0;
  logic [31:0] insn = '0;
  logic        insn_valid = 1'b0;

  logic [31:0] rdt1, rdt3, ccnt1, ccnt3, cnt1, cnt3;
  logic        ack1, err1, done1, to1, calc1;
  logic        ack3, err3, done3, to3, calc3;

  always #5 clk = ~clk;

  wb_mem_monitor #(.AW(30), .DEPTH(DEPTH), .WAIT_STATES(1), .TIMEOUT(100)) u_dut (
    .clk(clk), .reset(reset), .adr(adr), .dat(dat), .sel(sel), .we(we), .cyc(cyc1),
    .rdt(rdt1), .ack(ack1), .err(err1), .insn(insn), .insn_valid(insn_valid),
    .done(done1), .timeout(to1), .calc_seen(calc1), .calc_start_cnt(ccnt1), .cycle_cnt(cnt1));

  wb_mem_monitor #(.AW(30), .DEPTH(DEPTH), .WAIT_STATES(3), .TIMEOUT(100)) u_dut3 (
    .clk(clk), .reset(reset), .adr(adr), .dat(dat), .sel(sel), .we(we), .cyc(cyc3),
    .rdt(rdt3), .ack(ack3), .err(err3), .insn(insn), .insn_valid(insn_valid),
    .done(done3), .timeout(to3), .calc_seen(calc3), .calc_start_cnt(ccnt3), .cycle_cnt(cnt3));

  int checks = 0;
  int failures = 0;
  logic use3 = 1'b0;

  typedef struct packed {
    logic [31:0] rdt;
    logic        err;
    logic        chk_rdt;
  } exp_t;

  exp_t        sb[$];
  string       sb_tag[$];
  logic [31:0] model [logic [29:0]];

  logic        ack_m, err_m;
  logic [31:0] rdt_m;
  assign ack_m = use3 ? ack3 : ack1;
  assign err_m = use3 ? err3 : err1;
  assign rdt_m = use3 ? rdt3 : rdt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack pops one expected response.
  exp_t  mon_e;
  string mon_t;
  logic  prev_ack1 = 1'b0, prev_ack3 = 1'b0;
  always @(negedge clk) begin
    if (ack1) chk("ack1_single_cycle", 32'(prev_ack1), 32'd0);
    if (ack3) chk("ack3_single_cycle", 32'(prev_ack3), 32'd0);
    if (ack_m) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_ack: got ack=1 expected no pending cycle");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        mon_t = sb_tag.pop_front();
        if (mon_e.chk_rdt) chk({mon_t, "_rdt"}, rdt_m, mon_e.rdt);
        chk({mon_t, "_err"}, 32'(err_m), 32'(mon_e.err));
      end
    end
    prev_ack1 = ack1;
    prev_ack3 = ack3;
  end

  // Called on a negedge; returns on a negedge one idle cycle after the ack.
  task automatic bus(input string tag, input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic w);
    exp_t        e;
    logic [31:0] old;
    logic        inr, ex, got;
    int          lat;
    inr = ({2'b0, a} < 32'(DEPTH));
    ex  = (a == EXIT_ADR);
    old = model.exists(a) ? model[a] : 32'h0;
    e.rdt     = (inr && !ex) ? old : 32'h0;
    e.err     = !inr && !ex;
    e.chk_rdt = !(inr && !ex) || model.exists(a);
    sb.push_back(e);
    sb_tag.push_back(tag);
    if (w && inr && !ex) begin
      for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      model[a] = old;
    end
    adr = a; dat = d; sel = s; we = w;
    if (use3) cyc3 = 1'b1; else cyc1 = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = ack_m;
    end
    chk({tag, "_latency"}, 32'(lat), use3 ? 32'd4 : 32'd2);
    cyc1 = 1'b0; cyc3 = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cnt(input logic [31:0] n);
    int k;
    k = 0;
    while (cnt1 !== n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cycle_cnt", cnt1, n);
  endtask

  task automatic chk_rst3(input string tag);
    chk({tag, "_ack3"}, 32'(ack3), 32'd0);
    chk({tag, "_err3"}, 32'(err3), 32'd0);
    chk({tag, "_rdt3"}, rdt3, 32'd0);
    chk({tag, "_done3"}, 32'(done3), 32'd0);
    chk({tag, "_timeout3"}, 32'(to3), 32'd0);
    chk({tag, "_calc3"}, 32'(calc3), 32'd0);
    chk({tag, "_ccnt3"}, ccnt3, 32'd0);
    chk({tag, "_cnt3"}, cnt3, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ack1"}, 32'(ack1), 32'd0);
    chk({tag, "_err1"}, 32'(err1), 32'd0);
    chk({tag, "_rdt1"}, rdt1, 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
    chk({tag, "_timeout1"}, 32'(to1), 32'd0);
    chk({tag, "_calc1"}, 32'(calc1), 32'd0);
    chk({tag, "_ccnt1"}, ccnt1, 32'd0);
    chk({tag, "_cnt1"}, cnt1, 32'd0);
    chk_rst3(tag);
    reset = 1'b0;
  endtask

  int seen;

  initial begin
    @(negedge clk);
    do_reset("rst0");

    // calculate-instruction capture
    wait_cnt(32'd20);
    insn = 32'h0000_2027; insn_valid = 1'b0;
    @(negedge clk);
    chk("calc_invalid_ignored", 32'(calc1), 32'd0);
    wait_cnt(32'd30);
    insn = 32'h0000_3027; insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    chk("calc_nonmatch_ignored", 32'(calc1), 32'd0);
    wait_cnt(32'd40);
    insn = 32'h0000_2027; insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    chk("calc_seen", 32'(calc1), 32'd1);
    chk("calc_start_40", ccnt1, 32'd40);
    wait_cnt(32'd60);
    insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    chk("calc_start_kept", ccnt1, 32'd40);

    // timeout at cycle 100
    wait_cnt(32'd99);
    chk("timeout_before", 32'(to1), 32'd0);
    @(negedge clk);
    chk("timeout_set", 32'(to1), 32'd1);
    chk("timeout_cnt", cnt1, 32'd100);
    chk("timeout_no_done", 32'(done1), 32'd0);
    repeat (5) @(negedge clk);
    chk("cnt_frozen_timeout", cnt1, 32'd100);

    // bus traffic keeps working after timeout
    bus("w5", 30'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    bus("r5", 30'd5, 32'h0, 4'hF, 1'b0);
    bus("w7", 30'd7, 32'h11223344, 4'hF, 1'b1);
    bus("w7_lanes", 30'd7, 32'hAABBCCDD, 4'b0101, 1'b1);
    bus("r7", 30'd7, 32'h0, 4'hF, 1'b0);
    bus("r_depth", 30'(DEPTH), 32'h0, 4'hF, 1'b0);
    bus("w_oob", 30'd300, 32'h5555_5555, 4'hF, 1'b1);
    bus("exit_bad_dat", EXIT_ADR, 32'h0000_00ae, 4'hF, 1'b1);
    bus("exit_bad_sel", EXIT_ADR, EXIT_DAT, 4'h7, 1'b1);
    chk("exit_bad_no_done", 32'(done1), 32'd0);

    // memory survives reset; correct exit freezes the counter
    do_reset("rst1");
    bus("r5_after_rst", 30'd5, 32'h0, 4'hF, 1'b0);
    wait_cnt(32'd10);
    bus("exit_ok", EXIT_ADR, EXIT_DAT, 4'hF, 1'b1);
    chk("exit_done", 32'(done1), 32'd1);
    chk("exit_cnt", cnt1, 32'd12);
    repeat (3) @(negedge clk);
    chk("cnt_frozen_done", cnt1, 32'd12);
    chk("exit_no_timeout", 32'(to1), 32'd0);
    bus("r_depth_after_done", 30'(DEPTH), 32'h0, 4'hF, 1'b0);
    bus("r7_after_done", 30'd7, 32'h0, 4'hF, 1'b0);

    // exit landing on the timeout cycle
    do_reset("rst2");
    wait_cnt(32'd98);
    bus("exit_at_timeout", EXIT_ADR, EXIT_DAT, 4'hF, 1'b1);
    chk("race_done", 32'(done1), 32'd1);
    chk("race_cnt", cnt1, 32'd100);
    repeat (3) @(negedge clk);
    chk("race_no_timeout", 32'(to1), 32'd0);

    // 3-wait-state instance: latency, abort, reset mid-cycle
    do_reset("rst3");
    use3 = 1'b1;
    bus("w9", 30'd9, 32'h12345678, 4'hF, 1'b1);
    bus("r9", 30'd9, 32'h0, 4'hF, 1'b0);

    adr = 30'd9; dat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    cyc3 = 1'b0; we = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack3) seen++;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    bus("r9_after_abort", 30'd9, 32'h0, 4'hF, 1'b0);

    adr = 30'd9; dat = 32'hCAFE_F00D; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_rst3("rst_wait");
    cyc3 = 1'b0; we = 1'b0; reset = 1'b0;
    bus("r9_after_rst_wait", 30'd9, 32'h0, 4'hF, 1'b0);

    adr = 30'd9; dat = 32'hCAFE_F00D; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_ack_edge_ack3", 32'(ack3), 32'd0);
    cyc3 = 1'b0; we = 1'b0; reset = 1'b0;
    bus("r9_after_rst_ack", 30'd9, 32'h0, 4'hF, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
